// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and counter-width helper for serial_adder_ctrl
package serial_adder_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: adder bus; master drives start/a/b/cin, slave returns busy/done/sum/cout (+ovf with SERIAL_ADDER_OVF_EN)
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
  modport master(output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave(input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master(output start, a, b, cin, input busy, done, sum, cout);
  modport slave(input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl_bit_full_adder.sv
// bit_full_adder: combinational one-bit full adder; inputs a, b, cin; outputs s, co
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder FSM; ports clk, rst_n, bus (slave: start/a/b/cin in, busy/done/sum/cout out, ovf when SERIAL_ADDER_OVF_EN)
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CNT_W = cnt_w(WIDTH);
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic carry_q;
  logic [WIDTH-1:0] sha_q;
  logic [WIDTH-1:0] shb_q;
  logic [WIDTH-1:0] sum_q;
  logic busy_q;
  logic done_q;
  logic cout_q;
  logic s_d;
  logic co_d;
  logic last;
  bit_full_adder u_fa (.a(sha_q[0]), .b(shb_q[0]), .cin(carry_q), .s(s_d), .co(co_d));
  assign last = cnt_q == CNT_W'(WIDTH - 1);
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sha_q   <= '0;
      shb_q   <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sha_q   <= bus.a;
            shb_q   <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sum_q   <= {s_d, sum_q[WIDTH-1:1]};
          carry_q <= co_d;
          sha_q   <= sha_q >> 1;
          shb_q   <= shb_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= carry_q ^ co_d;
`endif
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed table plus corner sequences for serial_adder_ctrl at WIDTH 8 and 4
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) if4 ();
  serial_adder_ctrl #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder_ctrl #(.WIDTH(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, output int lat);
    @(negedge clk);
    if8.a = ta; if8.b = tb; if8.cin = tc; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc, output int lat);
    @(negedge clk);
    if4.a = ta; if4.b = tb; if4.cin = tc; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    lat = 0;
    while (!if4.done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int dones;
    vecs[0] = '{8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hC3, 8'h0F, 1'b0, 8'hD2, 1'b0, 1'b0};
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", 32'(if8.busy), 32'd0);
    chk("rst_done", 32'(if8.done), 32'd0);
    chk("rst_sum", 32'(if8.sum), 32'd0);
    chk("rst_cout", 32'(if8.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(if8.ovf), 32'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if8.a = vecs[i].a; if8.b = vecs[i].b; if8.cin = vecs[i].cin; if8.start = 1'b1;
      @(posedge clk); #1;
      if8.start = 1'b0;
      chk("busy_rise", 32'(if8.busy), 32'd1);
      lat = 0;
      while (!if8.done && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("latency", 32'(lat), 32'd8);
      chk("sum", 32'(if8.sum), 32'(vecs[i].sum));
      chk("cout", 32'(if8.cout), 32'(vecs[i].cout));
      chk("busy_at_done", 32'(if8.busy), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", 32'(if8.ovf), 32'(vecs[i].ovf));
`endif
      @(posedge clk); #1;
      chk("done_pulse", 32'(if8.done), 32'd0);
      chk("sum_hold", 32'(if8.sum), 32'(vecs[i].sum));
    end
    @(negedge clk);
    if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin
        @(negedge clk);
        if8.a = 8'h00; if8.b = 8'h00; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
      end
      @(posedge clk); #1;
      if (if8.done) begin
        dones++;
        chk("ignore_sum", 32'(if8.sum), 32'h30);
      end
    end
    chk("ignore_dones", 32'(dones), 32'd1);
    @(negedge clk);
    if8.a = 8'h5A; if8.b = 8'h33; if8.cin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", 32'(if8.busy), 32'd0);
    chk("midrst_sum", 32'(if8.sum), 32'd0);
    chk("midrst_done", 32'(if8.done), 32'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (if8.done) dones++;
    end
    chk("midrst_nodone", 32'(dones), 32'd0);
    run8(8'h01, 8'h01, 1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'd8);
    chk("post_rst_sum", 32'(if8.sum), 32'h02);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++) begin
          run4(4'(a), 4'(b), 1'(ci), lat);
          chk("sweep4", {8'(lat), 19'd0, if4.cout, if4.sum}, {8'd4, 19'd0, 5'(a + b + ci)});
          @(posedge clk); #1;
          chk("sweep4_pulse", 32'(if4.done), 32'd0);
        end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
